// File: rtl/mastermind_pkg.sv
// Purpose: shared Mastermind types and constants (peg colour type, guess geometry, entry FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mastermind_pkg;

    localparam int NUM_PEGS   = 4;   // fixed by the 2-bit position counter
    localparam int COLOR_W    = 3;
    localparam int NUM_COLORS = 6;   // legal colours are 0..NUM_COLORS-1

    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2,
        OFFER = 2'd3
    } entry_state_e;

    function automatic logic color_legal(input color_t c);
        return (int'(c) < NUM_COLORS);
    endfunction

endpackage

// File: rtl/button_pulse.sv
// Purpose: turns a raw asynchronous active-high button into one single-cycle pulse per press.
// Latency: press sampled at edge n gives pulse high during cycle n+2 (registered output).
// Backpressure: none; one pulse per rising edge of the synchronized button.
//
// Ports: clk, Reset (async active-low), btn (raw button), pulse (registered one-cycle pulse).
module button_pulse (
    input  logic clk,
    input  logic Reset,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
            pulse <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/guess_entry.sv
// Purpose: collects one 4-peg Mastermind guess from buttons/switches and offers it to the scorer.
// Latency: button press at edge n -> slot write and incr visible after edge n+3; guess_valid the cycle after submit.
// Backpressure: guess held stable in OFFER until guess_valid && guess_ready; buttons ignored meanwhile.
//
// Ports: clk, Reset (async active-low); place/submit/clear_btn raw buttons; color_sw switch colour;
//        pos from position counter; incr/cnt_reset drive that counter; guess/filled slot contents;
//        guess_valid/guess_ready handshake to scorer; bad_color pulse on rejected place.
module guess_entry
    import mastermind_pkg::*;
(
    input  logic                          clk,
    input  logic                          Reset,
    input  logic                          place_btn,
    input  logic                          submit_btn,
    input  logic                          clear_btn,
    input  logic [COLOR_W-1:0]            color_sw,
    input  logic [1:0]                    pos,
    output logic                          incr,
    output logic                          cnt_reset,
    output logic [NUM_PEGS*COLOR_W-1:0]   guess,
    output logic [NUM_PEGS-1:0]           filled,
    output logic                          guess_valid,
    input  logic                          guess_ready,
    output logic                          bad_color
);

    logic place_p;
    logic submit_p;
    logic clear_p;

    button_pulse u_place  (.clk(clk), .Reset(Reset), .btn(place_btn),  .pulse(place_p));
    button_pulse u_submit (.clk(clk), .Reset(Reset), .btn(submit_btn), .pulse(submit_p));
    button_pulse u_clear  (.clk(clk), .Reset(Reset), .btn(clear_btn),  .pulse(clear_p));

    entry_state_e        state_q, state_nxt;
    color_t              slot_q   [NUM_PEGS];
    color_t              slot_nxt [NUM_PEGS];
    logic [NUM_PEGS-1:0] filled_nxt;
    logic                incr_nxt;
    logic                bad_nxt;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= FLUSH;
            slot_q    <= '{default: '0};
            filled    <= '0;
            incr      <= 1'b0;
            bad_color <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            slot_q    <= slot_nxt;
            filled    <= filled_nxt;
            incr      <= incr_nxt;
            bad_color <= bad_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        slot_nxt   = slot_q;
        filled_nxt = filled;
        incr_nxt   = 1'b0;
        bad_nxt    = 1'b0;
        case (state_q)
            FLUSH: state_nxt = ENTRY;
            ENTRY: begin
                if (clear_p) begin
                    state_nxt = FLUSH;
                end else if (place_p) begin
                    if (color_legal(color_sw)) begin
                        slot_nxt[pos]   = color_sw;
                        filled_nxt[pos] = 1'b1;
                        incr_nxt        = 1'b1;
                    end else begin
                        bad_nxt = 1'b1;
                    end
                    if (&filled_nxt) state_nxt = FULL;
                end
            end
            FULL: begin
                if (clear_p)       state_nxt = FLUSH;
                else if (submit_p) state_nxt = OFFER;
            end
            OFFER: begin
                if (guess_ready) state_nxt = FLUSH;
            end
            default: state_nxt = FLUSH;
        endcase
        // Slots are zeroed on the way into FLUSH so they read 0 for the whole FLUSH cycle,
        // in step with cnt_reset clearing the counter.
        if (state_nxt == FLUSH || state_q == FLUSH) begin
            slot_nxt   = '{default: '0};
            filled_nxt = '0;
        end
    end

    for (genvar i = 0; i < NUM_PEGS; i++) begin : g_guess
        assign guess[i*COLOR_W +: COLOR_W] = slot_q[i];
    end

    assign cnt_reset   = (state_q == FLUSH);
    assign guess_valid = (state_q == OFFER);

endmodule

// File: doc/guess_entry.md
# guess_entry

Collects one Mastermind guess: conditions the raw place/submit/clear buttons, writes the switch-selected colour into the peg slot addressed by the 2-bit position counter, and pulses `incr` to advance that counter. Sits directly downstream of the position counter and consumes its `out`. Sits upstream of the scorer and offers a completed 4-peg guess over a valid/ready handshake. Also drives the counter's synchronous reset so that the position and the slot contents always clear together.

## Interface
- `NUM_PEGS`, 4: peg slots per guess. The position input is fixed at 2 bits, so the value is fixed at 4.
- `COLOR_W`, 3: bits per peg colour.
- `NUM_COLORS`, 6: legal colour codes are 0..NUM_COLORS-1.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `place_btn`  in  1  raw asynchronous button, active-high.
- `submit_btn`  in  1  raw asynchronous button, active-high.
- `clear_btn`  in  1  raw asynchronous button, active-high.
- `color_sw`  in  COLOR_W  colour selected on the switches.
- `pos`  in  2  current peg position, taken from the position counter's `out`.
- `incr`  out  1  registered one-cycle pulse to the counter's `incr` input.
- `cnt_reset`  out  1  drives the counter's active-high synchronous `Reset`.
- `guess`  out  NUM_PEGS*COLOR_W  peg i occupies bits [i*COLOR_W +: COLOR_W].
- `filled`  out  NUM_PEGS  bit i is set when slot i has been written.
- `guess_valid`  out  1  a guess is offered to the scorer.
- `guess_ready`  in  1  the scorer accepts the offered guess.
- `bad_color`  out  1  registered one-cycle pulse when a place is rejected for an illegal colour.

## Operation
- Each button passes through a two-flop synchronizer, then a rising-edge detector. This produces one single-cycle pulse per press: `place_p`, `submit_p`, `clear_p`.
- The block is a Moore FSM with states FLUSH, ENTRY, FULL and OFFER.
- **FLUSH**
  - `cnt_reset`=1; `guess` and `filled` are cleared.
  - Moves to ENTRY on the next cycle unconditionally.
- **ENTRY**
  - On `place_p`:
    - If `color_sw` < NUM_COLORS: write slot[`pos`] and set filled[`pos`]. `incr`=1 on the following cycle.
    - If `color_sw` >= NUM_COLORS: no write; `bad_color`=1 on the following cycle.
  - Writing an already-filled slot overwrites it and still pulses `incr`.
  - Moves to FULL when `filled` becomes all-ones.
  - `submit_p` is ignored.
- **FULL**
  - `place_p` and `submit_p`... `place_p` is ignored.
  - `submit_p` moves the FSM to OFFER.
- **OFFER**
  - `guess_valid`=1, and `guess` is held stable.
  - Moves to FLUSH on the cycle where `guess_valid` and `guess_ready` are both high.
  - All button pulses are ignored; the handshake cannot be aborted.
- **Clear**
  - `clear_p` in ENTRY or FULL moves the FSM to FLUSH.
  - Clear takes priority over a simultaneous place or submit.
- **Counter wrap**: the counter wraps 3→0. Once `filled` is all-ones, the FSM is in FULL and any further `pos` value is irrelevant.

## Timing
- **Reset state**: the FSM resets into FLUSH. While `Reset`=0:
  - `cnt_reset`=1;
  - `incr`, `bad_color` and `guess_valid` are 0;
  - `guess` and `filled` are 0;
  - synchronizer and edge flops are 0.
- **After reset release**: the first edge performs the FLUSH cycle, which clears the counter. The FSM is in ENTRY on the next cycle.
- **Button latency**: the press is sampled at edge n, and `place_p` is high during cycle n+2. The slot write and `incr` are visible after edge n+3. The counter's `pos` is updated after edge n+4.
- **Back-to-back places**: `pos` must be stable when `place_p` arrives, so placing the next peg requires a new press. Button presses cannot arrive faster than the counter's one-cycle update.
- **Moore outputs**: `guess_valid` and `cnt_reset` are decoded from the state register and are glitch-free. `guess_valid` rises the cycle after `submit_p`.
- **Handshake**: `guess_ready` may be high before `guess_valid`. Acceptance happens in the first OFFER cycle where `guess_ready` is high.
- **Reset mid-operation**: `Reset`=0 in any state returns immediately (asynchronously) to the FLUSH outputs, including dropping `guess_valid`.

## Structure
- Shared package `mastermind_pkg`:
  - `color_t` (logic [COLOR_W-1:0]);
  - constant `NUM_COLORS`;
  - FSM enum `entry_state_e` {FLUSH, ENTRY, FULL, OFFER}.
- Sub-module `button_pulse`: the two-flop synchronizer plus rising-edge detector, with inputs `clk`, `Reset` and `btn` and output `pulse`. It is instantiated three times.
- The FSM, slot registers and output decode live in `guess_entry`.

## Test plan
- **Reset then idle**: hold `Reset`=0 for 3 cycles, then release → `cnt_reset`=1 while in reset plus one cycle after release; then `guess`=0, `filled`=4'b0000, `guess_valid`=0.
- **Four places**: place colours 2, 5, 0, 3 with `pos` following a counter model → `incr` pulses 4 times, each exactly 1 cycle; `guess`=12'b011_000_101_010; `filled`=4'b1111; state FULL.
- **Illegal colour**: place with `color_sw`=7 at `pos`=1 → `bad_color` is a 1-cycle pulse; no `incr`; `filled` unchanged.
- **Submit with backpressure**: from FULL, press submit with `guess_ready`=0 for 5 cycles, then 1 → `guess_valid` is high for 6 cycles with `guess` stable; then `cnt_reset` pulses for one cycle; `filled`=0.
- **Clear priority**: in ENTRY with 2 pegs filled, press place and clear in the same cycle → no write, no `incr`; FLUSH clears all slots.
- **Reset mid-OFFER**: `Reset`=0 while `guess_valid`=1 → `guess_valid` falls without waiting for a clock edge; `guess` is 0 after release.
